// File: rtl/mapping_table_access_arbiter.sv
// Single-port owner of the frame-mapping table: clear sweep, config access, datapath lookups.
// Latency: config read and lookup results appear RAM_RD_LAT+1 cycles after issue; RAM port mux is combinational.
// Backpressure: config path never stalls; lookups are held off (ack low) by INIT or any config access.
// Optional: define MAPTBL_WR_FWD_EN to forward writes into lookups still waiting on RAM data.
module mapping_table_access_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int TBL_DEPTH  = 32,
    parameter int DATA_W     = 163,
    parameter int RAM_RD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tbl_clr,
    output logic              o_init_done,
    input  logic [ADDR_W-1:0] iv_cfg_addr,
    input  logic [DATA_W-1:0] iv_cfg_wdata,
    input  logic              i_cfg_wr,
    input  logic              i_cfg_rd,
    output logic [DATA_W-1:0] ov_cfg_rdata,
    output logic              o_cfg_busy,
    input  logic              i_lkp_req,
    input  logic [ADDR_W-1:0] iv_lkp_addr,
    output logic              o_lkp_ack,
    output logic              o_lkp_valid,
    output logic [ADDR_W-1:0] ov_lkp_addr,
    output logic [DATA_W-1:0] ov_lkp_rdata,
    output logic              o_lkp_hit,
    output logic [15:0]       ov_lkp_stall_cnt,
    output logic [ADDR_W-1:0] ov_ram_addr,
    output logic [DATA_W-1:0] ov_ram_wdata,
    output logic              o_ram_wr,
    output logic              o_ram_rd,
    input  logic [DATA_W-1:0] iv_ram_rdata
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam int         L       = RAM_RD_LAT;

    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              cfg_rd_issue;
    logic [L-1:0]      cfg_vld;
    logic [L-1:0]      cfg_zero;
    logic [L-1:0]      tag_vld;
    logic [ADDR_W-1:0] tag_addr [L];
    logic [DATA_W-1:0] lkp_data;

    assign o_init_done  = (state == ST_RUN);
    assign o_cfg_busy   = (state == ST_INIT);
    // A simultaneous write wins; the read is dropped entirely.
    assign cfg_rd_issue = i_cfg_rd & ~i_cfg_wr;

    // Clear-sweep FSM: one entry per cycle, restartable at any time by i_tbl_clr.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else if (i_tbl_clr) begin
            state <= ST_INIT;
            ptr   <= '0;
        end else if (state == ST_INIT) begin
            if (ptr == ADDR_W'(TBL_DEPTH - 1)) begin
                state <= ST_RUN;
                ptr   <= '0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // RAM port mux: sweep > config write > config read > lookup.
    always_comb begin
        ov_ram_addr  = '0;
        ov_ram_wdata = '0;
        o_ram_wr     = 1'b0;
        o_ram_rd     = 1'b0;
        o_lkp_ack    = 1'b0;
        if (i_rst_n) begin
            if (state == ST_INIT) begin
                ov_ram_addr = ptr;
                o_ram_wr    = 1'b1;
            end else if (i_cfg_wr) begin
                ov_ram_addr  = iv_cfg_addr;
                ov_ram_wdata = iv_cfg_wdata;
                o_ram_wr     = 1'b1;
            end else if (i_cfg_rd) begin
                ov_ram_addr = iv_cfg_addr;
                o_ram_rd    = 1'b1;
            end else if (i_lkp_req) begin
                ov_ram_addr = iv_lkp_addr;
                o_ram_rd    = 1'b1;
                o_lkp_ack   = 1'b1;
            end
        end
    end

    // Config read pipeline; reads issued during INIT never touch RAM and return zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_vld      <= '0;
            cfg_zero     <= '0;
            ov_cfg_rdata <= '0;
        end else begin
            cfg_vld[0]  <= cfg_rd_issue;
            cfg_zero[0] <= (state == ST_INIT);
            for (int i = 1; i < L; i++) begin
                cfg_vld[i]  <= cfg_vld[i-1];
                cfg_zero[i] <= cfg_zero[i-1];
            end
            if (cfg_vld[L-1]) begin
                ov_cfg_rdata <= cfg_zero[L-1] ? '0 : iv_ram_rdata;
            end
        end
    end

    // Lookup tag pipeline, aligned with RAM read latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_vld <= '0;
            for (int i = 0; i < L; i++) tag_addr[i] <= '0;
        end else begin
            tag_vld[0]  <= o_lkp_ack;
            tag_addr[0] <= iv_lkp_addr;
            for (int i = 1; i < L; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_addr[i] <= tag_addr[i-1];
            end
        end
    end

`ifdef MAPTBL_WR_FWD_EN
    logic [L-1:0]      fwd_vld;
    logic [DATA_W-1:0] fwd_dat [L];
    logic [L-1:0]      wr_hit;

    // Which in-flight lookups target the entry being written this cycle.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < L; i++) begin
            wr_hit[i] = o_ram_wr && (tag_addr[i] == ov_ram_addr);
        end
    end

    // Carry the most recent overlapping write alongside each in-flight lookup.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fwd_vld <= '0;
            for (int i = 0; i < L; i++) fwd_dat[i] <= '0;
        end else begin
            fwd_vld[0] <= 1'b0;
            fwd_dat[0] <= '0;
            for (int i = 1; i < L; i++) begin
                fwd_vld[i] <= wr_hit[i-1] | fwd_vld[i-1];
                fwd_dat[i] <= wr_hit[i-1] ? ov_ram_wdata : fwd_dat[i-1];
            end
        end
    end

    assign lkp_data = wr_hit[L-1]  ? ov_ram_wdata :
                      fwd_vld[L-1] ? fwd_dat[L-1] : iv_ram_rdata;
`else
    assign lkp_data = iv_ram_rdata;
`endif

    // Lookup result register: one-cycle valid pulse, payload held between results.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lkp_valid  <= 1'b0;
            ov_lkp_addr  <= '0;
            ov_lkp_rdata <= '0;
            o_lkp_hit    <= 1'b0;
        end else begin
            o_lkp_valid <= tag_vld[L-1];
            if (tag_vld[L-1]) begin
                ov_lkp_addr  <= tag_addr[L-1];
                ov_lkp_rdata <= lkp_data;
                o_lkp_hit    <= lkp_data[DATA_W-1];
            end
        end
    end

    // Saturating stall counter; survives table clears on purpose.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_lkp_stall_cnt <= '0;
        end else if ((state == ST_RUN) && i_lkp_req && !o_lkp_ack &&
                     (ov_lkp_stall_cnt != 16'hFFFF)) begin
            ov_lkp_stall_cnt <= ov_lkp_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mapping_table_access_arbiter.sv
// Bench for mapping_table_access_arbiter: directed vectors, corner sequences, randomized traffic.
// Expected values come from a transaction-level table model with due-cycle queues.
// RAM is modelled here with a two-cycle registered read.
module tb_mapping_table_access_arbiter;

    localparam int AW = 5;
    localparam int DW = 163;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_tbl_clr;
    logic          o_init_done;
    logic [AW-1:0] iv_cfg_addr;
    logic [DW-1:0] iv_cfg_wdata;
    logic          i_cfg_wr;
    logic          i_cfg_rd;
    logic [DW-1:0] ov_cfg_rdata;
    logic          o_cfg_busy;
    logic          i_lkp_req;
    logic [AW-1:0] iv_lkp_addr;
    logic          o_lkp_ack;
    logic          o_lkp_valid;
    logic [AW-1:0] ov_lkp_addr;
    logic [DW-1:0] ov_lkp_rdata;
    logic          o_lkp_hit;
    logic [15:0]   ov_lkp_stall_cnt;
    logic [AW-1:0] ov_ram_addr;
    logic [DW-1:0] ov_ram_wdata;
    logic          o_ram_wr;
    logic          o_ram_rd;
    logic [DW-1:0] iv_ram_rdata;

    mapping_table_access_arbiter dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tbl_clr(i_tbl_clr), .o_init_done(o_init_done),
        .iv_cfg_addr(iv_cfg_addr), .iv_cfg_wdata(iv_cfg_wdata), .i_cfg_wr(i_cfg_wr),
        .i_cfg_rd(i_cfg_rd), .ov_cfg_rdata(ov_cfg_rdata), .o_cfg_busy(o_cfg_busy),
        .i_lkp_req(i_lkp_req), .iv_lkp_addr(iv_lkp_addr), .o_lkp_ack(o_lkp_ack),
        .o_lkp_valid(o_lkp_valid), .ov_lkp_addr(ov_lkp_addr), .ov_lkp_rdata(ov_lkp_rdata),
        .o_lkp_hit(o_lkp_hit), .ov_lkp_stall_cnt(ov_lkp_stall_cnt), .ov_ram_addr(ov_ram_addr),
        .ov_ram_wdata(ov_ram_wdata), .o_ram_wr(o_ram_wr), .o_ram_rd(o_ram_rd),
        .iv_ram_rdata(iv_ram_rdata)
    );

    always #5 i_clk = ~i_clk;

    // Table RAM: write at the edge, read data registered twice.
    logic [DW-1:0] ram [32];
    logic [DW-1:0] ram_p0, ram_p1;
    always @(posedge i_clk) begin
        if (o_ram_wr) ram[ov_ram_addr] <= ov_ram_wdata;
        ram_p0 <= o_ram_rd ? ram[ov_ram_addr] : '0;
        ram_p1 <= ram_p0;
    end
    assign iv_ram_rdata = ram_p1;

    typedef struct { int due; logic [DW-1:0] data; } cret_t;
    typedef struct { int due; logic [AW-1:0] addr; logic [DW-1:0] data; } lret_t;
    typedef struct {
        bit ack; bit wr; bit rd; logic [AW-1:0] addr;
        bit lkp_valid; bit lkp_hit; bit busy; logic [DW-1:0] lkp_rdata; logic [DW-1:0] cfg_rdata;
    } samp_t;
    typedef struct {
        bit wr; bit rd; bit req; bit e_ack; bit e_wr; bit e_rd; logic [AW-1:0] e_addr;
    } vec_t;

    // Reference model state
    logic [DW-1:0] mem [32];
    bit            m_run;
    int            m_ptr;
    int            m_stall;
    logic [DW-1:0] m_cfg;
    bit            m_ack;
    cret_t         cq[$];
    lret_t         lq[$];
    int            cyc;

    int n_chk  = 0;
    int n_fail = 0;

    samp_t s;

    function automatic void chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", n, cyc, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rand_dat();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    // Table write; with forwarding, lookups acked in the previous two cycles see this data.
    function automatic void m_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        mem[a] = d;
`ifdef MAPTBL_WR_FWD_EN
        foreach (lq[i]) begin
            if (lq[i].addr == a && lq[i].due > cyc && lq[i].due <= cyc + 2) lq[i].data = d;
        end
`endif
    endfunction

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic step(input bit wr, input bit rd, input bit req, input bit clr,
                        input logic [AW-1:0] ca, input logic [AW-1:0] la,
                        input logic [DW-1:0] wd, output samp_t so);
        bit            e_wr, e_rd;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        i_cfg_wr = wr; i_cfg_rd = rd; i_lkp_req = req; i_tbl_clr = clr;
        iv_cfg_addr = ca; iv_lkp_addr = la; iv_cfg_wdata = wd;
        m_ack = 0; e_wr = 0; e_rd = 0; e_addr = '0; e_wd = '0;
        if (!m_run) begin
            e_wr = 1; e_addr = AW'(m_ptr);
        end else if (wr) begin
            e_wr = 1; e_addr = ca; e_wd = wd;
        end else if (rd) begin
            e_rd = 1; e_addr = ca;
        end else if (req) begin
            e_rd = 1; e_addr = la; m_ack = 1;
        end
        @(negedge i_clk);
        chk("lkp_ack", DW'(o_lkp_ack), DW'(m_ack));
        chk("ram_wr", DW'(o_ram_wr), DW'(e_wr));
        chk("ram_rd", DW'(o_ram_rd), DW'(e_rd));
        chk("ram_addr", DW'(ov_ram_addr), DW'(e_addr));
        chk("ram_wdata", ov_ram_wdata, e_wd);
        chk("init_done", DW'(o_init_done), DW'(m_run));
        chk("cfg_busy", DW'(o_cfg_busy), DW'(!m_run));
        chk("stall_cnt", DW'(ov_lkp_stall_cnt), DW'(m_stall));
        if (lq.size() > 0 && lq[0].due == cyc) begin
            chk("lkp_valid", DW'(o_lkp_valid), DW'(1));
            chk("lkp_addr", DW'(ov_lkp_addr), DW'(lq[0].addr));
            chk("lkp_rdata", ov_lkp_rdata, lq[0].data);
            chk("lkp_hit", DW'(o_lkp_hit), DW'(lq[0].data[DW-1]));
            void'(lq.pop_front());
        end else begin
            chk("lkp_valid_idle", DW'(o_lkp_valid), DW'(0));
        end
        if (cq.size() > 0 && cq[0].due == cyc) begin
            m_cfg = cq[0].data;
            void'(cq.pop_front());
        end
        chk("cfg_rdata", ov_cfg_rdata, m_cfg);
        so.ack = o_lkp_ack; so.wr = o_ram_wr; so.rd = o_ram_rd; so.addr = ov_ram_addr;
        so.lkp_valid = o_lkp_valid; so.lkp_hit = o_lkp_hit; so.busy = o_cfg_busy;
        so.lkp_rdata = ov_lkp_rdata; so.cfg_rdata = ov_cfg_rdata;
        @(posedge i_clk);
        if (!m_run) begin
            m_write(AW'(m_ptr), '0);
            if (rd && !wr) cq.push_back('{cyc + 3, '0});
            if (clr) m_ptr = 0;
            else if (m_ptr == 31) begin m_run = 1; m_ptr = 0; end
            else m_ptr++;
        end else begin
            if (wr) m_write(ca, wd);
            else if (rd) cq.push_back('{cyc + 3, mem[ca]});
            else if (req) lq.push_back('{cyc + 3, la, mem[la]});
            if (req && (wr || rd) && m_stall < 16'hFFFF) m_stall++;
            if (clr) begin m_run = 0; m_ptr = 0; end
        end
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, '0, s);
    endtask

    vec_t          vt [10];
    logic [DW-1:0] d1, d_old, d_new, dv;
    int            base;
    bit            req_on;
    logic [AW-1:0] req_addr;

    initial begin
        vt[0] = '{0, 1, 1, 0, 0, 1, 5'd7};
        vt[1] = '{0, 0, 1, 1, 0, 1, 5'd9};
        vt[2] = '{1, 0, 1, 0, 1, 0, 5'd7};
        vt[3] = '{0, 0, 1, 1, 0, 1, 5'd9};
        vt[4] = '{1, 1, 1, 0, 1, 0, 5'd7};
        vt[5] = '{0, 0, 1, 1, 0, 1, 5'd9};
        vt[6] = '{0, 0, 0, 0, 0, 0, 5'd0};
        vt[7] = '{0, 1, 0, 0, 0, 1, 5'd7};
        vt[8] = '{1, 0, 0, 0, 1, 0, 5'd7};
        vt[9] = '{1, 1, 0, 0, 1, 0, 5'd7};

        m_run = 0; m_ptr = 0; m_stall = 0; m_cfg = '0; cyc = 0;
        i_rst_n = 0; i_tbl_clr = 0; i_cfg_wr = 0; i_cfg_rd = 0; i_lkp_req = 0;
        iv_cfg_addr = '0; iv_lkp_addr = '0; iv_cfg_wdata = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_init_done", DW'(o_init_done), DW'(0));
        chk("rst_cfg_busy", DW'(o_cfg_busy), DW'(1));
        chk("rst_cfg_rdata", ov_cfg_rdata, '0);
        chk("rst_lkp_valid", DW'(o_lkp_valid), DW'(0));
        chk("rst_lkp_addr", DW'(ov_lkp_addr), DW'(0));
        chk("rst_lkp_rdata", ov_lkp_rdata, '0);
        chk("rst_lkp_hit", DW'(o_lkp_hit), DW'(0));
        chk("rst_stall", DW'(ov_lkp_stall_cnt), DW'(0));
        chk("rst_ram_wr", DW'(o_ram_wr), DW'(0));
        chk("rst_ram_rd", DW'(o_ram_rd), DW'(0));
        chk("rst_ram_addr", DW'(ov_ram_addr), DW'(0));
        @(posedge i_clk);
        #1 i_rst_n = 1;

        // Post-reset sweep then idle; cfg read of a cleared entry returns zero.
        idle(40);
        step(0, 1, 0, 0, 5'd5, '0, '0, s);
        idle(3);
        chk("cfg_rd_cleared", s.cfg_rdata, '0);

        // Write then look up the same entry.
        d1 = {1'b1, 162'h1234};
        step(1, 0, 0, 0, 5'd3, '0, d1, s);
        step(0, 0, 1, 0, '0, 5'd3, '0, s);
        chk("lkp3_ack", DW'(s.ack), DW'(1));
        idle(3);
        chk("lkp3_valid", DW'(s.lkp_valid), DW'(1));
        chk("lkp3_rdata", s.lkp_rdata, d1);
        chk("lkp3_hit", DW'(s.lkp_hit), DW'(1));

        // Mux priority vectors (cfg addr 7, lookup addr 9).
        for (int i = 0; i < 10; i++) begin
            step(vt[i].wr, vt[i].rd, vt[i].req, 0, 5'd7, 5'd9, rand_dat(), s);
            chk("vec_ack", DW'(s.ack), DW'(vt[i].e_ack));
            chk("vec_wr", DW'(s.wr), DW'(vt[i].e_wr));
            chk("vec_rd", DW'(s.rd), DW'(vt[i].e_rd));
            chk("vec_addr", DW'(s.addr), DW'(vt[i].e_addr));
        end
        idle(4);

        // Lookup starved by four config accesses, granted on the fifth cycle.
        base = m_stall;
        for (int i = 0; i < 4; i++) begin
            step(i[0], !i[0], 1, 0, 5'd20, 5'd2, rand_dat(), s);
            chk("starve_ack", DW'(s.ack), DW'(0));
        end
        step(0, 0, 1, 0, '0, 5'd2, '0, s);
        chk("starve_grant", DW'(s.ack), DW'(1));
        step(0, 0, 0, 0, '0, '0, '0, s);
        chk("starve_cnt", DW'(ov_lkp_stall_cnt), DW'(base + 4));
        idle(3);

        // Table clear wipes a written entry and ignores writes during the sweep.
        dv = rand_dat(); dv[DW-1] = 1'b1;
        step(1, 0, 0, 0, 5'd10, '0, dv, s);
        step(0, 0, 0, 1, '0, '0, '0, s);
        for (int i = 0; i < 32; i++) begin
            step(i == 5, 0, 0, 0, 5'd10, '0, dv, s);
            if (i == 5) chk("clr_busy", DW'(s.busy), DW'(1));
        end
        step(0, 0, 1, 0, '0, 5'd10, '0, s);
        chk("clr_lkp_ack", DW'(s.ack), DW'(1));
        idle(3);
        chk("clr_lkp_valid", DW'(s.lkp_valid), DW'(1));
        chk("clr_lkp_hit", DW'(s.lkp_hit), DW'(0));

        // Write to an entry while a lookup of it is in flight.
        d_old = rand_dat(); d_new = rand_dat();
        step(1, 0, 0, 0, 5'd4, '0, d_old, s);
        step(0, 0, 1, 0, '0, 5'd4, '0, s);
        step(1, 0, 0, 0, 5'd4, '0, d_new, s);
        idle(2);
`ifdef MAPTBL_WR_FWD_EN
        chk("fwd_rdata", s.lkp_rdata, d_new);
`else
        chk("nofwd_rdata", s.lkp_rdata, d_old);
`endif

        // Randomized traffic on a narrow address range to provoke collisions.
        req_on = 0; req_addr = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!req_on && ($urandom % 3 == 0)) begin
                req_on = 1; req_addr = AW'($urandom % 8);
            end
            step(($urandom % 4) == 0, ($urandom % 4) == 0, req_on, ($urandom % 200) == 0,
                 AW'($urandom % 8), req_addr, rand_dat(), s);
            if (m_ack) req_on = 0;
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mapping_table_access_arbiter.md
Name: mapping_table_access_arbiter

Overview:
- Single owner of the 32-entry x 163-bit frame-mapping table RAM in host_input_process/frame_resolution_mapping.
- Shares the one RAM port between two requesters: the config path (command parse/encapsulate, fixed-latency, no backpressure) and the datapath lookup (req/ack handshake).
- Runs a post-reset/on-demand table-clear sweep and counts lookup stalls.

Parameters:
ADDR_W, 5, table address width
TBL_DEPTH, 32, number of entries (2**ADDR_W)
DATA_W, 163, entry width; bit DATA_W-1 = entry valid
RAM_RD_LAT, 2, RAM read latency in cycles (rd asserted cycle t, data valid cycle t+RAM_RD_LAT)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_tbl_clr  in  1  pulse: restart clear sweep
o_init_done  out  1  high when sweep finished (RUN state)
iv_cfg_addr  in  ADDR_W  config entry address
iv_cfg_wdata  in  DATA_W  config write data
i_cfg_wr  in  1  config write strobe
i_cfg_rd  in  1  config read strobe
ov_cfg_rdata  out  DATA_W  config read return data
o_cfg_busy  out  1  high in INIT; config accesses not applied
i_lkp_req  in  1  lookup request, held until ack
iv_lkp_addr  in  ADDR_W  lookup address, stable while req
o_lkp_ack  out  1  lookup issued this cycle (combinational)
o_lkp_valid  out  1  lookup result valid pulse
ov_lkp_addr  out  ADDR_W  address of returned lookup
ov_lkp_rdata  out  DATA_W  returned entry
o_lkp_hit  out  1  returned entry valid bit
ov_lkp_stall_cnt  out  16  saturating count of cycles req high and ack low in RUN
ov_ram_addr  out  ADDR_W  RAM address
ov_ram_wdata  out  DATA_W  RAM write data
o_ram_wr  out  1  RAM write
o_ram_rd  out  1  RAM read
iv_ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset: FSM=INIT, sweep ptr=0; o_init_done=0, o_cfg_busy=1, ov_cfg_rdata=0, o_lkp_valid=0, ov_lkp_addr=0, ov_lkp_rdata=0, o_lkp_hit=0, ov_lkp_stall_cnt=0; RAM outputs 0.
- FSM INIT: each cycle write 0 to ptr (o_ram_wr=1, o_ram_rd=0), ptr++; after writing TBL_DEPTH-1 -> RUN next cycle (exactly TBL_DEPTH cycles). o_lkp_ack=0.
- FSM RUN: o_init_done=1, o_cfg_busy=0. i_tbl_clr in RUN or INIT -> INIT, ptr=0 (restart); in-flight reads still return.
- RAM port mux is combinational, priority: INIT sweep > cfg wr > cfg rd > lookup. Lookup granted (o_lkp_ack=1) only in RUN with i_cfg_wr=0 and i_cfg_rd=0. Unselected RAM outputs 0.
- i_cfg_wr and i_cfg_rd both high: write wins; read dropped, no return.
- Config read latency fixed: data on ov_cfg_rdata exactly RAM_RD_LAT+1 cycles after i_cfg_rd (registered from iv_ram_rdata); held until next config return. Config read in INIT: no RAM access, returns 0 at same latency. Config write in INIT: discarded.
- Lookup: tag pipeline of depth RAM_RD_LAT carries {valid, addr}; o_lkp_valid pulses RAM_RD_LAT+1 cycles after ack with ov_lkp_addr, ov_lkp_rdata, o_lkp_hit=rdata[DATA_W-1]. Back-to-back acks give back-to-back results, in order.
- Stall counter: +1 per RUN cycle with i_lkp_req=1 & o_lkp_ack=0; saturates at 16'hFFFF; not cleared by i_tbl_clr.

Optional Feature:
- MAPTBL_WR_FWD_EN defined: a config write to address A while a lookup to A is in the tag pipeline (acked within last RAM_RD_LAT cycles) replaces that lookup's returned data with the written data (latest write wins); same applies to clear-sweep writes (data 0).
- Undefined: lookup returns raw RAM data; read-during-write result is RAM-defined.

Test Plan:
- Reset, hold idle 40 cycles -> o_ram_wr high addr 0..31 cycles 0..31, o_init_done rises cycle 32; cfg read addr 5 returns 0 at +3.
- RUN: cfg write addr 3 data {1'b1,162'h1234}; lookup addr 3 -> ack same cycle, o_lkp_valid +3, rdata matches, o_lkp_hit=1.
- Lookup req held while cfg rd/wr every cycle for 4 cycles -> ack 0 those cycles, stall_cnt=4, ack on cycle 5.
- Cfg rd addr 7 and lookup addr 9 same cycle -> cfg data at +3, lookup acked next cycle, result +3 after ack.
- i_tbl_clr after writing addr 10 -> 32-cycle sweep, o_cfg_busy=1, cfg write during sweep discarded, lookup addr 10 after returns hit=0.
- MAPTBL_WR_FWD_EN: lookup addr 4 acked, cfg write addr 4 next cycle with D -> lookup returns D (undefined: old data).
